// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: control/register-file handshake bundle for alu_exec_stage
interface alu_exec_stage_if #(parameter int W = 8, parameter int D = 2);
  logic         i_start;
  logic [2:0]   i_op;
  logic [W-1:0] i_operand_a;
  logic [W-1:0] i_operand_b;
  logic [D-1:0] i_dest_addr;
  logic         o_busy;
  logic         o_done;
  logic         o_carry;
  logic         o_zero;
  logic         o_write_en;
  logic [D-1:0] o_waddr;
  logic [W-1:0] o_data_in;
  modport master (
    output i_start, i_op, i_operand_a, i_operand_b, i_dest_addr,
    input  o_busy, o_done, o_carry, o_zero, o_write_en, o_waddr, o_data_in
  );
  modport slave (
    input  i_start, i_op, i_operand_a, i_operand_b, i_dest_addr,
    output o_busy, o_done, o_carry, o_zero, o_write_en, o_waddr, o_data_in
  );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage, single-cycle ALU ops plus iterative shift-add MUL when ALU_EXEC_MUL_EN is defined
// (otherwise op 111 is a NOP that pulses Done without writing).
module alu_exec_stage #(
  parameter int W = 8,
  parameter int D = 2
) (
  input logic             i_clk,
  input logic             i_rst_n,
  alu_exec_stage_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;
  localparam int CW = $clog2(W);
  state_t       r_state;
  logic [W-1:0] r_data;
  logic [D-1:0] r_waddr;
  logic         r_carry;
  logic         r_zero;
  logic         r_wr_en;
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W-1:0] w_res;
  logic         w_cy;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [2:0]   w_op;
  assign w_a  = bus.i_operand_a;
  assign w_b  = bus.i_operand_b;
  assign w_op = bus.i_op;
  always_comb begin
    w_sum  = {1'b0, w_a} + {1'b0, w_b};
    w_diff = {1'b0, w_a} - {1'b0, w_b};
    w_res  = w_op == 3'd0 ? w_sum[W-1:0] :
             w_op == 3'd1 ? w_diff[W-1:0] :
             w_op == 3'd2 ? (w_a & w_b) :
             w_op == 3'd3 ? (w_a | w_b) :
             w_op == 3'd4 ? (w_a ^ w_b) :
             w_op == 3'd5 ? {w_a[W-2:0], 1'b0} :
             w_op == 3'd6 ? {1'b0, w_a[W-1:1]} : '0;
    w_cy   = w_op == 3'd0 ? w_sum[W] :
             w_op == 3'd1 ? w_diff[W] :
             w_op == 3'd5 ? w_a[W-1] :
             w_op == 3'd6 ? w_a[0] : 1'b0;
  end
`ifdef ALU_EXEC_MUL_EN
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] w_acc_nxt;
  // multiplicand shifts left and multiplier shifts right so bit 0 always selects the next partial product
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_waddr  <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_wr_en  <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (bus.i_start) begin
          if (w_op == 3'b111) begin
`ifdef ALU_EXEC_MUL_EN
            r_state  <= S_MUL;
            r_wr_en  <= 1'b1;
            r_waddr  <= bus.i_dest_addr;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mcand  <= {{W{1'b0}}, w_a};
            r_mplier <= w_b;
`else
            r_state  <= S_WB;
            r_wr_en  <= 1'b0;
`endif
          end else begin
            r_state <= S_WB;
            r_wr_en <= 1'b1;
            r_waddr <= bus.i_dest_addr;
            r_data  <= w_res;
            r_carry <= w_cy;
            r_zero  <= w_res == '0;
          end
        end
`ifdef ALU_EXEC_MUL_EN
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_WB;
            r_data  <= w_acc_nxt[W-1:0];
            r_carry <= |w_acc_nxt[2*W-1:W];
            r_zero  <= w_acc_nxt[W-1:0] == '0;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.o_busy     = r_state != S_IDLE;
  assign bus.o_done     = r_state == S_WB;
  assign bus.o_write_en = (r_state == S_WB) && r_wr_en;
  assign bus.o_waddr    = r_waddr;
  assign bus.o_data_in  = r_data;
  assign bus.o_carry    = r_carry;
  assign bus.o_zero     = r_zero;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vector table plus hand-written multi-cycle sequences for alu_exec_stage
module tb_alu_exec_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_exec_stage_if #(.W(8), .D(2)) bus ();
  alu_exec_stage #(.W(8), .D(2)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] d;
    logic [7:0] res;
    logic       c;
    logic       z;
  } vec_t;
  vec_t vecs[12];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.o_busy), 0);
    check({tag, "_done"},  32'(bus.o_done), 0);
    check({tag, "_we"},    32'(bus.o_write_en), 0);
    check({tag, "_carry"}, 32'(bus.o_carry), 0);
    check({tag, "_zero"},  32'(bus.o_zero), 0);
    check({tag, "_data"},  32'(bus.o_data_in), 0);
    check({tag, "_waddr"}, 32'(bus.o_waddr), 0);
  endtask
  task automatic check_wb(input string tag, input logic [1:0] d, input logic [7:0] res, input logic c, input logic z);
    check({tag, "_we"},    32'(bus.o_write_en), 1);
    check({tag, "_done"},  32'(bus.o_done), 1);
    check({tag, "_waddr"}, 32'(bus.o_waddr), 32'(d));
    check({tag, "_data"},  32'(bus.o_data_in), 32'(res));
    check({tag, "_carry"}, 32'(bus.o_carry), 32'(c));
    check({tag, "_zero"},  32'(bus.o_zero), 32'(z));
  endtask
  task automatic scramble();
    bus.i_op        = 3'($urandom);
    bus.i_operand_a = 8'($urandom);
    bus.i_operand_b = 8'($urandom);
    bus.i_dest_addr = 2'($urandom);
  endtask
  // presents one Start cycle; returns at the negedge after the accepting edge with operands scrambled
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [1:0] d);
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_op        = op;
    bus.i_operand_a = a;
    bus.i_operand_b = b;
    bus.i_dest_addr = d;
    @(negedge clk);
    bus.i_start = 1'b0;
    scramble();
  endtask
  task automatic wait_we(output int n, input logic hammer);
    n = 1;
    while (!bus.o_write_en && n < 20) begin
      if (hammer) begin
        scramble();
        bus.i_start = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    bus.i_start = 1'b0;
  endtask
  initial begin
    int n;
    int seen;
    bus.i_start = 1'b0;
    bus.i_op = '0;
    bus.i_operand_a = '0;
    bus.i_operand_b = '0;
    bus.i_dest_addr = '0;
    vecs[0]  = '{3'd0, 8'hF0, 8'h20, 2'd2, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{3'd1, 8'h05, 8'h05, 2'd1, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{3'd1, 8'h03, 8'h05, 2'd3, 8'hFE, 1'b1, 1'b0};
    vecs[3]  = '{3'd2, 8'hF0, 8'h3C, 2'd0, 8'h30, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 8'h0F, 8'hF0, 2'd1, 8'hFF, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 8'hAA, 8'hAA, 2'd2, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{3'd5, 8'h81, 8'h00, 2'd3, 8'h02, 1'b1, 1'b0};
    vecs[7]  = '{3'd6, 8'h81, 8'h00, 2'd0, 8'h40, 1'b1, 1'b0};
    vecs[8]  = '{3'd5, 8'h40, 8'hFF, 2'd1, 8'h80, 1'b0, 1'b0};
    vecs[9]  = '{3'd6, 8'h02, 8'hFF, 2'd2, 8'h01, 1'b0, 1'b0};
    vecs[10] = '{3'd0, 8'h7F, 8'h01, 2'd3, 8'h80, 1'b0, 1'b0};
    vecs[11] = '{3'd0, 8'hFF, 8'h01, 2'd0, 8'h00, 1'b1, 1'b1};
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d);
      check_wb($sformatf("vec%0d", i), vecs[i].d, vecs[i].res, vecs[i].c, vecs[i].z);
      @(negedge clk);
      check($sformatf("vec%0d_idle", i), 32'(bus.o_busy), 0);
      check($sformatf("vec%0d_we_off", i), 32'(bus.o_write_en), 0);
    end
    issue(3'd0, 8'hF0, 8'h20, 2'd2);
    check_wb("pre_rst", 2'd2, 8'h10, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op = 3'd0;
    bus.i_operand_a = 8'h01;
    bus.i_operand_b = 8'h01;
    bus.i_dest_addr = 2'd3;
    @(negedge clk);
    check_wb("hold_start", 2'd3, 8'h02, 1'b0, 1'b0);
    bus.i_op = 3'd2;
    bus.i_operand_a = 8'hFF;
    bus.i_operand_b = 8'hFF;
    bus.i_dest_addr = 2'd0;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("ign_busy", 32'(bus.o_busy), 0);
    check("ign_data", 32'(bus.o_data_in), 32'h02);
    check("ign_waddr", 32'(bus.o_waddr), 3);
`ifdef ALU_EXEC_MUL_EN
    issue(3'd7, 8'h0C, 8'h0B, 2'd1);
    wait_we(n, 1'b0);
    check("mul1_latency", n, 9);
    check_wb("mul1", 2'd1, 8'h84, 1'b0, 1'b0);
    @(negedge clk);
    check("mul1_idle", 32'(bus.o_busy), 0);
    issue(3'd7, 8'h10, 8'h10, 2'd2);
    wait_we(n, 1'b0);
    check("mul2_latency", n, 9);
    check_wb("mul2", 2'd2, 8'h00, 1'b1, 1'b1);
    issue(3'd7, 8'hFF, 8'hFF, 2'd3);
    wait_we(n, 1'b0);
    check_wb("mul3", 2'd3, 8'h01, 1'b1, 1'b0);
    issue(3'd7, 8'h0C, 8'h0B, 2'd0);
    wait_we(n, 1'b1);
    check("mul_hammer_latency", n, 9);
    check_wb("mul_hammer", 2'd0, 8'h84, 1'b0, 1'b0);
    @(negedge clk);
    check("mul_hammer_idle", 32'(bus.o_busy), 0);
    issue(3'd7, 8'h0C, 8'h0B, 2'd2);
    repeat (3) @(negedge clk);
    check("mul_rst_busy_before", 32'(bus.o_busy), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mul_rst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_write_en) seen = 1;
    end
    check("mul_rst_no_we", seen, 0);
    issue(3'd7, 8'h03, 8'h05, 2'd1);
    wait_we(n, 1'b0);
    check("mul_after_rst_latency", n, 9);
    check_wb("mul_after_rst", 2'd1, 8'h0F, 1'b0, 1'b0);
`else
    issue(3'd7, 8'h55, 8'hAA, 2'd1);
    check("nop_done", 32'(bus.o_done), 1);
    check("nop_we", 32'(bus.o_write_en), 0);
    check("nop_busy", 32'(bus.o_busy), 1);
    check("nop_data", 32'(bus.o_data_in), 32'h02);
    check("nop_waddr", 32'(bus.o_waddr), 3);
    check("nop_carry", 32'(bus.o_carry), 0);
    check("nop_zero", 32'(bus.o_zero), 0);
    @(negedge clk);
    check("nop_idle", 32'(bus.o_busy), 0);
    check("nop_we_off", 32'(bus.o_write_en), 0);
    issue(3'd1, 8'h03, 8'h05, 2'd2);
    check_wb("after_nop", 2'd2, 8'hFE, 1'b1, 1'b0);
`endif
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
